// File: rtl/multicycle_ctrl_fsm_if.sv
// Control-port bundle between the multicycle datapath sequencer and its environment.
// The master drives instruction class, function bits and memory readiness; the slave drives control outputs.
interface multicycle_ctrl_fsm_if #(
    parameter int CNT_W = 32
);
    logic [1:0]       Op;
    logic [5:0]       Funct;
    logic             MemReady;

    logic             IRWrite;
    logic             NextPC;
    logic             RegW;
    logic             MemW;
    logic             Branch;
    logic             AdrSrc;
    logic             ALUSrcA;
    logic             ALUOp;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ResultSrc;
    logic [3:0]       State;
    logic             IllegalOp;
    logic [CNT_W-1:0] RetireCnt;

    modport master (
        output Op, Funct, MemReady,
        input  IRWrite, NextPC, RegW, MemW, Branch,
        input  AdrSrc, ALUSrcA, ALUOp, ALUSrcB, ResultSrc,
        input  State, IllegalOp, RetireCnt
    );

    modport slave (
        input  Op, Funct, MemReady,
        output IRWrite, NextPC, RegW, MemW, Branch,
        output AdrSrc, ALUSrcA, ALUOp, ALUSrcB, ResultSrc,
        output State, IllegalOp, RetireCnt
    );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle processor control sequencer with registered Moore control outputs
// and a retired-instruction counter.
//
// state    | meaning
// FETCH    | read instruction, wait for memory, bump PC on MemReady
// DECODE   | read register file, dispatch on Op (Op=11 retires as illegal)
// MEMADR   | compute memory address (base + imm)
// MEMREAD  | load access, hold until MemReady
// MEMWB    | write load data to register file
// MEMWRITE | store access, MemW held until MemReady
// EXECR    | ALU op, register operand
// EXECI    | ALU op, immediate operand
// ALUWB    | write ALU result to register file
// BRANCH   | compute branch target, assert Branch
module multicycle_ctrl_fsm #(
    parameter int CNT_W = 32
) (
    input  logic                   CLK,
    input  logic                   RESET,
    multicycle_ctrl_fsm_if.slave   bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    typedef struct packed {
        logic       fetch;
        logic       reg_w;
        logic       mem_w;
        logic       branch;
        logic       adr_src;
        logic       alu_src_a;
        logic       alu_op;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
    } ctrl_t;

    state_t           state;
    state_t           state_nxt;
    ctrl_t            ctrl_q;
    logic             retire;
    logic [CNT_W-1:0] retire_cnt;
    logic             unused_funct;

    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.fetch      = 1'b1;
                c.alu_src_a  = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
            end
            DECODE: begin
                c.alu_src_a  = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
            end
            MEMADR: begin
                c.alu_src_b  = 2'b01;
            end
            MEMREAD: begin
                c.adr_src    = 1'b1;
            end
            MEMWB: begin
                c.result_src = 2'b01;
                c.reg_w      = 1'b1;
            end
            MEMWRITE: begin
                c.adr_src    = 1'b1;
                c.mem_w      = 1'b1;
            end
            EXECR: begin
                c.alu_op     = 1'b1;
            end
            EXECI: begin
                c.alu_src_b  = 2'b01;
                c.alu_op     = 1'b1;
            end
            ALUWB: begin
                c.reg_w      = 1'b1;
            end
            BRANCH: begin
                c.alu_src_b  = 2'b01;
                c.result_src = 2'b10;
                c.branch     = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_nxt = FETCH;
        case (state)
            FETCH:    state_nxt = bus.MemReady ? DECODE : FETCH;
            DECODE: begin
                case (bus.Op)
                    2'b00:   state_nxt = bus.Funct[5] ? EXECI : EXECR;
                    2'b01:   state_nxt = MEMADR;
                    2'b10:   state_nxt = BRANCH;
                    default: state_nxt = FETCH;
                endcase
            end
            MEMADR:   state_nxt = bus.Funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD:  state_nxt = bus.MemReady ? MEMWB : MEMREAD;
            MEMWRITE: state_nxt = bus.MemReady ? FETCH : MEMWRITE;
            EXECR:    state_nxt = ALUWB;
            EXECI:    state_nxt = ALUWB;
            default:  state_nxt = FETCH;
        endcase
    end

    // An instruction retires on the edge that leaves its last state.
    always_comb begin
        retire = 1'b0;
        case (state)
            MEMWB, ALUWB, BRANCH: retire = 1'b1;
            MEMWRITE:             retire = bus.MemReady;
            DECODE:               retire = (bus.Op == 2'b11);
            default:              retire = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= FETCH;
            ctrl_q     <= decode_ctrl(FETCH);
            retire_cnt <= '0;
        end else begin
            state      <= state_nxt;
            ctrl_q     <= decode_ctrl(state_nxt);
            retire_cnt <= retire_cnt + CNT_W'(retire);
        end
    end

    // IRWrite/NextPC follow MemReady within FETCH and are forced low while reset is held.
    assign bus.IRWrite   = ctrl_q.fetch & bus.MemReady & ~RESET;
    assign bus.NextPC    = ctrl_q.fetch & bus.MemReady & ~RESET;
    assign bus.RegW      = ctrl_q.reg_w;
    assign bus.MemW      = ctrl_q.mem_w;
    assign bus.Branch    = ctrl_q.branch;
    assign bus.AdrSrc    = ctrl_q.adr_src;
    assign bus.ALUSrcA   = ctrl_q.alu_src_a;
    assign bus.ALUOp     = ctrl_q.alu_op;
    assign bus.ALUSrcB   = ctrl_q.alu_src_b;
    assign bus.ResultSrc = ctrl_q.result_src;
    assign bus.State     = state;
    assign bus.IllegalOp = (state == DECODE) && (bus.Op == 2'b11);
    assign bus.RetireCnt = retire_cnt;

    assign unused_funct  = ^bus.Funct[4:1];

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed-vector bench for multicycle_ctrl_fsm: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_multicycle_ctrl_fsm;

    localparam int CNT_W = 4;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
                           S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
                           S_ALUWB = 4'd8, S_BRANCH = 4'd9;

    logic CLK = 1'b0;
    logic RESET = 1'b1;

    multicycle_ctrl_fsm_if #(.CNT_W(CNT_W)) bus ();

    multicycle_ctrl_fsm #(.CNT_W(CNT_W)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0]       st;
        logic [12:0]      outs;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    int   cyc_idx = 0;

    // Control outputs per state: {IRWrite,NextPC,RegW,MemW,Branch,AdrSrc,ALUSrcA,ALUOp,ALUSrcB,ResultSrc,IllegalOp}
    function automatic logic [12:0] exp_outs(input logic [3:0] s, input logic mr,
                                             input logic [1:0] op, input logic rst);
        logic       irw, regw, memw, br, adr, srca, aluop, ill;
        logic [1:0] srcb, res;
        irw = 1'b0; regw = 1'b0; memw = 1'b0; br = 1'b0; adr = 1'b0;
        srca = 1'b0; aluop = 1'b0; ill = 1'b0; srcb = 2'b00; res = 2'b00;
        case (s)
            S_FETCH:    begin srca = 1'b1; srcb = 2'b10; res = 2'b10; irw = mr & ~rst; end
            S_DECODE:   begin srca = 1'b1; srcb = 2'b10; res = 2'b10; ill = (op == 2'b11); end
            S_MEMADR:   begin srcb = 2'b01; end
            S_MEMREAD:  begin adr = 1'b1; end
            S_MEMWB:    begin res = 2'b01; regw = 1'b1; end
            S_MEMWRITE: begin adr = 1'b1; memw = 1'b1; end
            S_EXECR:    begin aluop = 1'b1; end
            S_EXECI:    begin srcb = 2'b01; aluop = 1'b1; end
            S_ALUWB:    begin regw = 1'b1; end
            S_BRANCH:   begin srcb = 2'b01; res = 2'b10; br = 1'b1; end
            default:    ;
        endcase
        return {irw, irw, regw, memw, br, adr, srca, aluop, srcb, res, ill};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s cycle %0d: got %0h want %0h", name, cyc_idx, act, exp);
        else
            passed++;
    endtask

    // One cycle: drive inputs just after the edge, queue what the DUT must show this cycle.
    task automatic cyc(input logic rst, input logic [1:0] op, input logic [5:0] f,
                       input logic mr, input logic [3:0] st, input int cnt);
        exp_t e;
        RESET        = rst;
        bus.Op       = op;
        bus.Funct    = f;
        bus.MemReady = mr;
        e.st   = st;
        e.outs = exp_outs(st, mr, op, rst);
        e.cnt  = cnt[CNT_W-1:0];
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("state", 32'(bus.State), 32'(e.st));
            chk("ctrl_outs", 32'({bus.IRWrite, bus.NextPC, bus.RegW, bus.MemW, bus.Branch,
                                  bus.AdrSrc, bus.ALUSrcA, bus.ALUOp, bus.ALUSrcB,
                                  bus.ResultSrc, bus.IllegalOp}), 32'(e.outs));
            chk("retire_cnt", 32'(bus.RetireCnt), 32'(e.cnt));
            cyc_idx++;
        end
    end

    initial begin
        bus.Op = 2'b00;
        bus.Funct = 6'h00;
        bus.MemReady = 1'b1;
        @(posedge CLK);
        #1;

        // reset state with MemReady high: IRWrite must stay low
        cyc(1, 2'b00, 6'h20, 1, S_FETCH, 0);

        // data-processing immediate: 0,1,7,8,0
        cyc(0, 2'b00, 6'h20, 1, S_FETCH,  0);
        cyc(0, 2'b00, 6'h20, 1, S_DECODE, 0);
        cyc(0, 2'b00, 6'h20, 1, S_EXECI,  0);
        cyc(0, 2'b00, 6'h20, 1, S_ALUWB,  0);

        // load with three MemReady-low cycles in MEMREAD
        cyc(0, 2'b01, 6'h01, 1, S_FETCH,   1);
        cyc(0, 2'b01, 6'h01, 1, S_DECODE,  1);
        cyc(0, 2'b01, 6'h01, 1, S_MEMADR,  1);
        cyc(0, 2'b01, 6'h01, 0, S_MEMREAD, 1);
        cyc(0, 2'b01, 6'h01, 0, S_MEMREAD, 1);
        cyc(0, 2'b01, 6'h01, 0, S_MEMREAD, 1);
        cyc(0, 2'b01, 6'h01, 1, S_MEMREAD, 1);
        cyc(0, 2'b01, 6'h01, 1, S_MEMWB,   1);

        // store with two MemReady-low cycles: MemW for three cycles
        cyc(0, 2'b01, 6'h00, 1, S_FETCH,    2);
        cyc(0, 2'b01, 6'h00, 1, S_DECODE,   2);
        cyc(0, 2'b01, 6'h00, 1, S_MEMADR,   2);
        cyc(0, 2'b01, 6'h00, 0, S_MEMWRITE, 2);
        cyc(0, 2'b01, 6'h00, 0, S_MEMWRITE, 2);
        cyc(0, 2'b01, 6'h00, 1, S_MEMWRITE, 2);

        // fetch stall for five cycles, then illegal Op
        for (int i = 0; i < 5; i++)
            cyc(0, 2'b11, 6'h00, 0, S_FETCH, 3);
        cyc(0, 2'b11, 6'h00, 1, S_FETCH,  3);
        cyc(0, 2'b11, 6'h00, 1, S_DECODE, 3);

        // data-processing register
        cyc(0, 2'b00, 6'h00, 1, S_FETCH,  4);
        cyc(0, 2'b00, 6'h00, 1, S_DECODE, 4);
        cyc(0, 2'b00, 6'h00, 1, S_EXECR,  4);
        cyc(0, 2'b00, 6'h00, 1, S_ALUWB,  4);

        // store abandoned by reset during a MEMWRITE stall
        cyc(0, 2'b01, 6'h00, 1, S_FETCH,    5);
        cyc(0, 2'b01, 6'h00, 1, S_DECODE,   5);
        cyc(0, 2'b01, 6'h00, 1, S_MEMADR,   5);
        cyc(0, 2'b01, 6'h00, 0, S_MEMWRITE, 5);
        cyc(1, 2'b01, 6'h00, 0, S_FETCH,    0);
        cyc(1, 2'b01, 6'h00, 1, S_FETCH,    0);

        // sixteen branches: counter reaches 15 then wraps to 0
        for (int k = 0; k < 16; k++) begin
            cyc(0, 2'b10, 6'h00, 1, S_FETCH,  k);
            cyc(0, 2'b10, 6'h00, 1, S_DECODE, k);
            cyc(0, 2'b10, 6'h00, 1, S_BRANCH, k);
        end
        cyc(0, 2'b10, 6'h00, 1, S_FETCH,  0);
        cyc(0, 2'b10, 6'h00, 1, S_DECODE, 0);
        cyc(0, 2'b10, 6'h00, 1, S_BRANCH, 0);

        // reset asserted mid-cycle where BRANCH would be shown
        cyc(0, 2'b10, 6'h00, 1, S_FETCH,  1);
        cyc(0, 2'b10, 6'h00, 1, S_DECODE, 1);
        cyc(1, 2'b10, 6'h00, 1, S_FETCH,  0);
        cyc(1, 2'b10, 6'h00, 1, S_FETCH,  0);

        // first edge after release evaluates FETCH normally
        cyc(0, 2'b10, 6'h00, 1, S_FETCH,  0);
        cyc(0, 2'b10, 6'h00, 1, S_DECODE, 0);
        cyc(0, 2'b10, 6'h00, 1, S_BRANCH, 0);
        cyc(0, 2'b10, 6'h00, 1, S_FETCH,  1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(negedge CLK);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain: got %0d pending expectations want 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl_fsm.md
MULTICYCLE_CTRL_FSM -- requirements
Module: multicycle_ctrl_fsm

Interface
REQ-001 The block SHALL have one parameter: CNT_W, default 32, width of the retired-instruction counter.
REQ-002 The block SHALL have port CLK, input, 1 bit: the only clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port Op, input, 2 bits: instruction class (00 data-processing, 01 memory, 10 branch, 11 illegal).
REQ-005 The block SHALL have port Funct, input, 6 bits: Funct[5] is the immediate flag and Funct[0] is load when 1, store when 0.
REQ-006 The block SHALL have port MemReady, input, 1 bit: the memory access completes this cycle.
REQ-007 The block SHALL have enable outputs IRWrite, NextPC, RegW, MemW and Branch, each 1 bit.
REQ-008 The block SHALL have outputs AdrSrc (1 bit), ALUSrcA (1 bit) and ALUOp (1 bit).
REQ-009 The block SHALL have outputs ALUSrcB (2 bits) and ResultSrc (2 bits).
REQ-010 The block SHALL have output State, 4 bits: the current state encoding.
REQ-011 The block SHALL have output IllegalOp, 1 bit: a one-cycle pulse flagging an illegal Op.
REQ-012 The block SHALL have output RetireCnt, CNT_W bits: the count of retired instructions.

Function
REQ-013 States SHALL be encoded FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9.
REQ-014 Codes 10-15 SHALL transition to FETCH on the next edge with all enables at 0.
REQ-015 FETCH SHALL hold while MemReady=0 and go to DECODE when MemReady=1.
REQ-016 DECODE SHALL go to MEMADR when Op=01 and to BRANCH when Op=10.
REQ-017 DECODE SHALL go to EXECI when Op=00 and Funct[5]=1, and to EXECR when Op=00 and Funct[5]=0.
REQ-018 DECODE SHALL go to FETCH when Op=11.
REQ-019 MEMADR SHALL go to MEMREAD when Funct[0]=1 and to MEMWRITE when Funct[0]=0.
REQ-020 MEMREAD SHALL hold while MemReady=0 and go to MEMWB when MemReady=1.
REQ-021 MEMWRITE SHALL hold while MemReady=0 and go to FETCH when MemReady=1.
REQ-022 MEMWB, ALUWB and BRANCH SHALL go to FETCH unconditionally, and EXECR and EXECI SHALL go to ALUWB.
REQ-023 Outputs SHALL be Moore-decoded from State; the only exception is FETCH IRWrite/NextPC gating by MemReady.
REQ-024 Every output not listed for a state SHALL be 0.
REQ-025 FETCH SHALL drive AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUOp=0, ResultSrc=10, and IRWrite=NextPC=MemReady.
REQ-026 DECODE SHALL drive ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
REQ-027 MEMADR SHALL drive ALUSrcA=0, ALUSrcB=01, ALUOp=0.
REQ-028 MEMREAD SHALL drive AdrSrc=1 and ResultSrc=00.
REQ-029 MEMWB SHALL drive ResultSrc=01 and RegW=1.
REQ-030 MEMWRITE SHALL drive AdrSrc=1, ResultSrc=00, and MemW=1 for every cycle including stall cycles.
REQ-031 EXECR SHALL drive ALUSrcA=0, ALUSrcB=00, ALUOp=1.
REQ-032 EXECI SHALL drive ALUSrcA=0, ALUSrcB=01, ALUOp=1.
REQ-033 ALUWB SHALL drive ResultSrc=00 and RegW=1.
REQ-034 BRANCH SHALL drive ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1.
REQ-035 IllegalOp SHALL be 1 in DECODE when Op=11, and only then.
REQ-036 RetireCnt SHALL increment by 1 on each edge that leaves MEMWB, ALUWB or BRANCH.
REQ-037 RetireCnt SHALL increment by 1 on each edge that leaves MEMWRITE with MemReady=1.
REQ-038 RetireCnt SHALL increment by 1 on each edge that leaves DECODE with Op=11.
REQ-039 RetireCnt SHALL wrap from 2^CNT_W-1 to 0 with no flag.
REQ-040 Instruction latency SHALL be, with MemReady tied to 1: load 5 cycles, store 4, data-processing 4, branch 3, illegal 2.

Reset
REQ-041 RESET=1 SHALL force State=FETCH and RetireCnt=0 immediately, independent of CLK.
REQ-042 While RESET=1, IRWrite, NextPC, RegW, MemW, Branch and IllegalOp SHALL be 0, and mux selects SHALL take their FETCH values.
REQ-043 Reset asserted in any state, including during a MEMWRITE stall, SHALL abandon the instruction without incrementing RetireCnt.
REQ-044 After RESET is released, the first rising edge SHALL evaluate FETCH normally.

Verification
REQ-045 Bench SHALL cover: MemReady=1, Op=00, Funct[5]=1 -> States 0,1,7,8,0; RegW=1 only in state 8; RetireCnt 0->1.
REQ-046 Bench SHALL cover: Op=01, Funct[0]=1, MemReady low 3 cycles in MEMREAD -> state 3 held 4 cycles, then 4 with RegW=1, then 0; RetireCnt +1.
REQ-047 Bench SHALL cover: store with MemReady low 2 cycles -> MemW=1 for 3 consecutive cycles, then State=0.
REQ-048 Bench SHALL cover: FETCH with MemReady=0 for 5 cycles -> IRWrite=NextPC=0, State=0 throughout; first MemReady=1 cycle -> IRWrite=1, then State=1.
REQ-049 Bench SHALL cover: Op=11 in DECODE -> IllegalOp=1 for exactly 1 cycle, then State=0; RetireCnt +1.
REQ-050 Bench SHALL cover: preload RetireCnt=2^CNT_W-1 via branch sequences with CNT_W=4 (15 branches), then 1 more branch -> RetireCnt=0; mid-BRANCH RESET -> State=0, Branch=0 asynchronously.
